sum_accumulator: RTL

//  Downstream stage of the 4-bit ripple-carry adder. Accepts {carry, sum} results
//  (5-bit, 0..31) over a valid/ready handshake and accumulates NUM_SAMPLES of them

---
 rtl/sum_acc_pkg.sv | 17 +
 rtl/sum_accumulator.sv | 119 +++++++++++
 2 files changed

// File: rtl/sum_acc_pkg.sv
// Shared types and defaults for the sum accumulator stage.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package sum_acc_pkg;

    // Width of one adder result {carry, sum[3:0]}
    localparam int OPND_W          = 5;
    localparam int ACC_W_DEF       = 8;
    localparam int NUM_SAMPLES_DEF = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_e;

endpackage

// File: rtl/sum_accumulator.sv
// Accumulates NUM_SAMPLES {carry,sum} adder results into an ACC_W-bit total per frame.
// Latency: out_valid rises the cycle after the last accepted operand; all outputs registered.
// Backpressure: in_ready only while accumulating; the result is held in DONE until out_ready.
// Build option: ACC_SATURATE_EN clamps the total at all-ones on overflow instead of wrapping.
module sum_accumulator
    import sum_acc_pkg::*;
#(
    parameter int ACC_W       = ACC_W_DEF,
    parameter int NUM_SAMPLES = NUM_SAMPLES_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       sum_in,
    input  logic             carry_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] acc_out,
    output logic             overflow,
    output logic             busy
);

    localparam int                CNT_W    = $clog2(NUM_SAMPLES + 1);
    localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(NUM_SAMPLES - 1);

    state_e             state_q, state_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               ovf_q, ovf_d;
    logic               in_ready_q, in_ready_d;
    logic               out_valid_q, out_valid_d;
    logic               busy_q, busy_d;

    logic [OPND_W-1:0]  operand;
    logic [ACC_W:0]     sum_w;
    logic [ACC_W-1:0]   add_res;
    logic               beat;

    assign operand = {carry_in, sum_in};
    assign beat    = in_valid && in_ready_q;
    assign sum_w   = {1'b0, acc_q} + {{(ACC_W + 1 - OPND_W){1'b0}}, operand};

    // Accumulator update value: wrap modulo 2^ACC_W, or clamp at all-ones on carry-out
    always_comb begin
`ifdef ACC_SATURATE_EN
        add_res = sum_w[ACC_W] ? {ACC_W{1'b1}} : sum_w[ACC_W-1:0];
`else
        add_res = sum_w[ACC_W-1:0];
`endif
    end

    // Next-state and next-output logic; outputs are decoded from the next state
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        ovf_d   = ovf_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    acc_d   = '0;
                    cnt_d   = '0;
                    ovf_d   = 1'b0;
                    state_d = ACCUM;
                end
            end
            ACCUM: begin
                if (beat) begin
                    acc_d = add_res;
                    ovf_d = ovf_q | sum_w[ACC_W];
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == LAST_CNT) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                // start in the exit cycle is deliberately ignored
                if (out_valid_q && out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        in_ready_d  = (state_d == ACCUM);
        out_valid_d = (state_d == DONE);
        busy_d      = (state_d != IDLE);
    end

    // State, datapath and registered outputs; reset discards any frame in progress
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            acc_q       <= '0;
            cnt_q       <= '0;
            ovf_q       <= 1'b0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            ovf_q       <= ovf_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign acc_out   = acc_q;
    assign overflow  = ovf_q;
    assign busy      = busy_q;

endmodule
